// File: rtl/exec_pkg.sv
// Shared types and encodings for the execute/issue stage: opselect codes,
// control-word layout, FSM states and the operand-2 select code.
package exec_pkg;

    localparam logic [2:0] OPSEL_SHIFT_REG   = 3'b000;
    localparam logic [2:0] OPSEL_ARITH_LOGIC = 3'b001;
    localparam logic [2:0] OPSEL_MEM_WRITE   = 3'b100;
    localparam logic [2:0] OPSEL_MEM_READ    = 3'b101;

    localparam int CTRL_WIDTH     = 7;
    localparam int CTRL_OP_LSB    = 4;
    localparam int CTRL_FLAG_BIT  = 3;
    localparam int CTRL_OPSEL_LSB = 0;

    typedef enum logic [1:0] {RUN, WAIT_MEM, DRAIN} exec_state_t;

    typedef enum logic [1:0] {A2_HOLD, A2_SRC2, A2_IMM} aluin2_sel_t;

    typedef struct packed {
        logic [2:0] operation;
        logic       imm_flag;
        logic [2:0] opselect;
    } ctrl_word_t;

    function automatic ctrl_word_t unpack_ctrl(input logic [CTRL_WIDTH-1:0] word);
        ctrl_word_t c;
        c.operation = word[CTRL_OP_LSB +: 3];
        c.imm_flag  = word[CTRL_FLAG_BIT];
        c.opselect  = word[CTRL_OPSEL_LSB +: 3];
        return c;
    endfunction

endpackage

// File: rtl/exec_ctrl_decode.sv
// Combinational decode of the control word into register-slot load values:
// operand-2 select, shift amount, unit enables and memory-access flags.
module exec_ctrl_decode import exec_pkg::*; #(
    parameter int SHIFT_WIDTH = 5
) (
    input  logic [CTRL_WIDTH-1:0]  control_in,
    input  logic                   imm_shift_src,
    input  logic [SHIFT_WIDTH-1:0] imm_shamt,
    input  logic [SHIFT_WIDTH-1:0] src2_shamt,
    output logic [2:0]             operation,
    output logic [2:0]             opselect,
    output aluin2_sel_t            aluin2_sel,
    output logic [SHIFT_WIDTH-1:0] shift_amt,
    output logic                   enable_arith,
    output logic                   enable_shift,
    output logic                   is_mem_read,
    output logic                   is_mem_write
);

    ctrl_word_t ctrl;

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        ctrl         = unpack_ctrl(control_in);
        operation    = ctrl.operation;
        opselect     = ctrl.opselect;
        aluin2_sel   = A2_HOLD;
        shift_amt    = '0;
        enable_arith = 1'b0;
        enable_shift = 1'b0;
        is_mem_read  = 1'b0;
        is_mem_write = 1'b0;
        case (ctrl.opselect)
            OPSEL_ARITH_LOGIC: begin
                enable_arith = 1'b1;
                aluin2_sel   = ctrl.imm_flag ? A2_IMM : A2_SRC2;
            end
            OPSEL_SHIFT_REG: begin
                enable_shift = 1'b1;
                shift_amt    = imm_shift_src ? src2_shamt : imm_shamt;
            end
            OPSEL_MEM_READ:  is_mem_read  = ctrl.imm_flag;
            OPSEL_MEM_WRITE: is_mem_write = ctrl.imm_flag;
            default: ;
        endcase
    end

endmodule

// File: rtl/execute_issue_stage.sv
// Execute/issue stage: decodes the control word, loads a registered output
// slot under valid/ready handshakes, waits on memory reads and drains on flush.
module execute_issue_stage import exec_pkg::*; #(
    parameter int DATA_WIDTH    = 32,
    parameter int SHIFT_WIDTH   = $clog2(DATA_WIDTH),
    parameter int IMM_SHIFT_LSB = 6,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  src1,
    input  logic [DATA_WIDTH-1:0]  src2,
    input  logic [DATA_WIDTH-1:0]  imm,
    input  logic [CTRL_WIDTH-1:0]  control_in,
    input  logic                   flush,
    output logic                   mem_rd_req,
    input  logic                   mem_rd_valid,
    input  logic [DATA_WIDTH-1:0]  mem_rd_data,
    output logic                   mem_write_en,
    output logic [DATA_WIDTH-1:0]  mem_data_write_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  aluin1,
    output logic [DATA_WIDTH-1:0]  aluin2,
    output logic [2:0]             operation_out,
    output logic [2:0]             opselect_out,
    output logic [SHIFT_WIDTH-1:0] shift_number,
    output logic                   enable_arith,
    output logic                   enable_shift,
    output logic [CNT_WIDTH-1:0]   stall_cycles
);

    exec_state_t            state, state_next;
    logic [2:0]             dec_operation, dec_opselect;
    aluin2_sel_t            dec_aluin2_sel;
    logic [SHIFT_WIDTH-1:0] dec_shift;
    logic                   dec_en_arith, dec_en_shift, dec_mem_read, dec_mem_write;
    logic                   accept, stall;

    exec_ctrl_decode #(.SHIFT_WIDTH(SHIFT_WIDTH)) u_decode (
        .control_in    (control_in),
        .imm_shift_src (imm[2]),
        .imm_shamt     (imm[IMM_SHIFT_LSB +: SHIFT_WIDTH]),
        .src2_shamt    (src2[SHIFT_WIDTH-1:0]),
        .operation     (dec_operation),
        .opselect      (dec_opselect),
        .aluin2_sel    (dec_aluin2_sel),
        .shift_amt     (dec_shift),
        .enable_arith  (dec_en_arith),
        .enable_shift  (dec_en_shift),
        .is_mem_read   (dec_mem_read),
        .is_mem_write  (dec_mem_write)
    );

    // Held low during reset so nothing is accepted before release.
    assign in_ready           = reset && (state == RUN) && !flush && (!out_valid || out_ready);
    assign accept             = in_valid && in_ready;
    assign stall              = out_valid && !out_ready;
    assign mem_write_en       = accept && dec_mem_write;
    assign mem_data_write_out = src2;

    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (accept && dec_mem_read) state_next = WAIT_MEM;
            // A response coinciding with flush is dropped; nothing is left to drain.
            WAIT_MEM: if (mem_rd_valid) state_next = RUN;
                      else if (flush) state_next = DRAIN;
            DRAIN:    if (mem_rd_valid) state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            aluin1        <= '0;
            aluin2        <= '0;
            operation_out <= '0;
            opselect_out  <= '0;
            shift_number  <= '0;
            enable_arith  <= 1'b0;
            enable_shift  <= 1'b0;
            mem_rd_req    <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            mem_rd_req <= accept && dec_mem_read;
            if (stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;

            if (flush) begin
                out_valid    <= 1'b0;
                enable_arith <= 1'b0;
                enable_shift <= 1'b0;
            end else if (accept) begin
                aluin1        <= src1;
                operation_out <= dec_operation;
                opselect_out  <= dec_opselect;
                shift_number  <= dec_shift;
                enable_arith  <= dec_en_arith;
                enable_shift  <= dec_en_shift;
                out_valid     <= !dec_mem_read;
                case (dec_aluin2_sel)
                    A2_SRC2: aluin2 <= src2;
                    A2_IMM:  aluin2 <= imm;
                    default: ;
                endcase
            end else if ((state == WAIT_MEM) && mem_rd_valid) begin
                aluin2       <= mem_rd_data;
                enable_arith <= 1'b1;
                enable_shift <= 1'b0;
                shift_number <= '0;
                out_valid    <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute_issue_stage.sv
// Directed bench for execute_issue_stage; a second instance with a 2-bit
// stall counter shares all inputs to exercise saturation.
module tb_execute_issue_stage;

    localparam int DW = 32;
    localparam int SW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid, flush, mem_rd_valid, out_ready;
    logic [DW-1:0] src1, src2, imm, mem_rd_data;
    logic [6:0]    control_in;

    logic          in_ready, mem_rd_req, mem_write_en, out_valid, enable_arith, enable_shift;
    logic [DW-1:0] mem_data_write_out, aluin1, aluin2;
    logic [2:0]    operation_out, opselect_out;
    logic [SW-1:0] shift_number;
    logic [15:0]   stall_cycles;

    logic          s_in_ready, s_mem_rd_req, s_mem_write_en, s_out_valid, s_enable_arith, s_enable_shift;
    logic [DW-1:0] s_mem_data_write_out, s_aluin1, s_aluin2;
    logic [2:0]    s_operation_out, s_opselect_out;
    logic [SW-1:0] s_shift_number;
    logic [1:0]    s_stall_cycles;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    execute_issue_stage u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .imm(imm), .control_in(control_in), .flush(flush),
        .mem_rd_req(mem_rd_req), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .mem_write_en(mem_write_en), .mem_data_write_out(mem_data_write_out),
        .out_valid(out_valid), .out_ready(out_ready), .aluin1(aluin1), .aluin2(aluin2),
        .operation_out(operation_out), .opselect_out(opselect_out),
        .shift_number(shift_number), .enable_arith(enable_arith),
        .enable_shift(enable_shift), .stall_cycles(stall_cycles)
    );

    execute_issue_stage #(.CNT_WIDTH(2)) u_dut_small (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .src1(src1), .src2(src2), .imm(imm), .control_in(control_in), .flush(flush),
        .mem_rd_req(s_mem_rd_req), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .mem_write_en(s_mem_write_en), .mem_data_write_out(s_mem_data_write_out),
        .out_valid(s_out_valid), .out_ready(out_ready), .aluin1(s_aluin1), .aluin2(s_aluin2),
        .operation_out(s_operation_out), .opselect_out(s_opselect_out),
        .shift_number(s_shift_number), .enable_arith(s_enable_arith),
        .enable_shift(s_enable_shift), .stall_cycles(s_stall_cycles)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0; mem_rd_valid = 1'b0; out_ready = 1'b1;
        src1 = '0; src2 = '0; imm = '0; mem_rd_data = '0; control_in = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({out_valid, enable_arith, enable_shift, mem_rd_req, operation_out, opselect_out, shift_number} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got v=%b ea=%b es=%b req=%b op=%b sel=%b sh=%0d, required all 0",
                     out_valid, enable_arith, enable_shift, mem_rd_req, operation_out, opselect_out, shift_number);
        end
        tests_run++;
        if ({aluin1, aluin2, stall_cycles} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got a1=%h a2=%h stall=%0d, required 0", aluin1, aluin2, stall_cycles);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_arith();
        in_valid = 1'b1; control_in = 7'b010_1_001; src1 = 32'd5; imm = 32'd9; src2 = 32'd77;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, aluin1, aluin2, operation_out, opselect_out, enable_arith, enable_shift} !==
            {1'b1, 32'd5, 32'd9, 3'b010, 3'b001, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL arith_imm: got v=%b a1=%h a2=%h op=%b sel=%b ea=%b es=%b, required 1 5 9 010 001 1 0",
                     out_valid, aluin1, aluin2, operation_out, opselect_out, enable_arith, enable_shift);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL arith_drop_valid: got %b required 0", out_valid);
        end
    endtask

    task automatic test_shift_back_to_back();
        in_valid = 1'b1; control_in = 7'b011_0_000; src1 = 32'd1; src2 = 32'h1F;
        imm = 32'h0000_0340;
        tick();
        tests_run++;
        if ({out_valid, shift_number, enable_shift, enable_arith, aluin2} !== {1'b1, 5'd13, 1'b1, 1'b0, 32'd9}) begin
            tests_failed++;
            $display("FAIL shift_imm: got v=%b sh=%0d es=%b ea=%b a2=%h, required 1 13 1 0 9",
                     out_valid, shift_number, enable_shift, enable_arith, aluin2);
        end
        imm = 32'h0000_0004; src1 = 32'd2;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, shift_number, enable_shift, aluin1} !== {1'b1, 5'd31, 1'b1, 32'd2}) begin
            tests_failed++;
            $display("FAIL shift_src2_b2b: got v=%b sh=%0d es=%b a1=%h, required 1 31 1 2",
                     out_valid, shift_number, enable_shift, aluin1);
        end
        tick();
    endtask

    task automatic test_mem_read();
        in_valid = 1'b1; control_in = 7'b011_1_101; src1 = 32'd7;
        tick();
        in_valid = 1'b0;
        #1;
        tests_run++;
        if ({mem_rd_req, in_ready, out_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL rd_req_issue: got req=%b rdy=%b v=%b, required 1 0 0", mem_rd_req, in_ready, out_valid);
        end
        tick();
        tests_run++;
        if ({mem_rd_req, in_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rd_wait: got req=%b rdy=%b, required 0 0", mem_rd_req, in_ready);
        end
        tick();
        tick();
        mem_rd_valid = 1'b1; mem_rd_data = 32'hDEADBEEF;
        tick();
        mem_rd_valid = 1'b0;
        tests_run++;
        if ({out_valid, aluin1, aluin2, enable_arith, enable_shift, shift_number} !==
            {1'b1, 32'd7, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0}) begin
            tests_failed++;
            $display("FAIL rd_response: got v=%b a1=%h a2=%h ea=%b es=%b sh=%0d, required 1 7 deadbeef 1 0 0",
                     out_valid, aluin1, aluin2, enable_arith, enable_shift, shift_number);
        end
        mem_rd_valid = 1'b1; mem_rd_data = 32'h0000_1234;
        tick();
        mem_rd_valid = 1'b0;
        tests_run++;
        if ({out_valid, aluin2} !== {1'b0, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("FAIL rd_stray_ignored: got v=%b a2=%h, required 0 deadbeef", out_valid, aluin2);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0; in_valid = 1'b1; control_in = 7'b001_0_001; src1 = 32'd3; src2 = 32'd4;
        tick();
        src1 = 32'd8;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests_run++;
            if ({out_valid, in_ready, aluin1, aluin2} !== {1'b1, 1'b0, 32'd3, 32'd4}) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d: got v=%b rdy=%b a1=%h a2=%h, required 1 0 3 4",
                         i, out_valid, in_ready, aluin1, aluin2);
            end
        end
        tests_run++;
        if ({stall_cycles, s_stall_cycles} !== {16'd4, 2'd3}) begin
            tests_failed++;
            $display("FAIL stall_count_4: got %0d/%0d required 4/3", stall_cycles, s_stall_cycles);
        end
        tick();
        tests_run++;
        if ({stall_cycles, s_stall_cycles} !== {16'd5, 2'd3}) begin
            tests_failed++;
            $display("FAIL stall_saturate: got %0d/%0d required 5/3", stall_cycles, s_stall_cycles);
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release_ready: got %b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, aluin1, stall_cycles} !== {1'b1, 32'd8, 16'd5}) begin
            tests_failed++;
            $display("FAIL stall_release_load: got v=%b a1=%h stall=%0d, required 1 8 5",
                     out_valid, aluin1, stall_cycles);
        end
        tick();
    endtask

    task automatic test_flush_drain();
        in_valid = 1'b1; control_in = 7'b000_1_101; src1 = 32'd11; src2 = 32'd4;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        #1;
        tests_run++;
        if ({mem_rd_req, in_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL flush_with_req: got req=%b rdy=%b, required 1 0", mem_rd_req, in_ready);
        end
        tick();
        flush = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, out_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL drain_ready: got rdy=%b v=%b, required 0 0", in_ready, out_valid);
        end
        tick();
        mem_rd_valid = 1'b1; mem_rd_data = 32'h0000_0055;
        tick();
        mem_rd_valid = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, in_ready, aluin2} !== {1'b0, 1'b1, 32'd4}) begin
            tests_failed++;
            $display("FAIL drain_discard: got v=%b rdy=%b a2=%h, required 0 1 4", out_valid, in_ready, aluin2);
        end
    endtask

    task automatic test_mem_write();
        in_valid = 1'b1; control_in = 7'b000_1_100; src2 = 32'hA5; out_ready = 1'b1;
        #1;
        tests_run++;
        if ({mem_write_en, mem_data_write_out} !== {1'b1, 32'hA5}) begin
            tests_failed++;
            $display("FAIL wr_strobe: got en=%b data=%h, required 1 a5", mem_write_en, mem_data_write_out);
        end
        tick();
        in_valid = 1'b0;
        #1;
        tests_run++;
        if ({mem_write_en, out_valid, opselect_out, enable_arith, enable_shift} !== {1'b0, 1'b1, 3'b100, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL wr_slot: got en=%b v=%b sel=%b ea=%b es=%b, required 0 1 100 0 0",
                     mem_write_en, out_valid, opselect_out, enable_arith, enable_shift);
        end
        in_valid = 1'b1; flush = 1'b1;
        #1;
        tests_run++;
        if ({mem_write_en, in_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL wr_flushed: got en=%b rdy=%b, required 0 0", mem_write_en, in_ready);
        end
        tick();
        in_valid = 1'b0; flush = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_flush_valid: got %b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_wait();
        in_valid = 1'b1; control_in = 7'b101_1_101; src1 = 32'd77;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({aluin1, mem_rd_req} !== {32'd77, 1'b1}) begin
            tests_failed++;
            $display("FAIL midreset_pre: got a1=%h req=%b, required 4d 1", aluin1, mem_rd_req);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, mem_rd_req, mem_write_en, aluin1, aluin2, operation_out, opselect_out,
             shift_number, enable_arith, enable_shift, stall_cycles} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_clear: got v=%b req=%b a1=%h a2=%h op=%b sel=%b stall=%0d, required all 0",
                     out_valid, mem_rd_req, aluin1, aluin2, operation_out, opselect_out, stall_cycles);
        end
        tick();
        reset = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_ready: got %b required 1", in_ready);
        end
        mem_rd_valid = 1'b1; mem_rd_data = 32'h0000_0099;
        tick();
        mem_rd_valid = 1'b0;
        tests_run++;
        if ({out_valid, aluin2, mem_rd_req} !== {1'b0, 32'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL midreset_no_replay: got v=%b a2=%h req=%b, required 0 0 0", out_valid, aluin2, mem_rd_req);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_arith();
        test_shift_back_to_back();
        test_mem_read();
        test_backpressure();
        test_flush_drain();
        test_mem_write();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/execute_issue_stage.md
Name: execute_issue_stage

Overview:
- Parametrised successor to the Stage-1 execute/operand-select stage of the ALU preprocessor.
- Decodes the 7-bit control word and selects ALU operands, shift amount and unit enables.
- Adds valid/ready handshakes on both sides and a multi-cycle memory-read wait.
- Adds flush with outstanding-read drain and a saturating stall counter. Sits between decode and the arithmetic/shift units.

Parameters:
- DATA_WIDTH, 32, width of src1/src2/imm/memory data/ALU operands
- SHIFT_WIDTH, $clog2(DATA_WIDTH), width of shift_number
- IMM_SHIFT_LSB, 6, LSB of the shift-amount field inside imm
- CNT_WIDTH, 16, width of stall_cycles counter

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- src1, src2  in  DATA_WIDTH each  register operands
- imm  in  DATA_WIDTH  immediate
- control_in  in  7  [6:4] operation, [3] imm/reg flag, [2:0] opselect
- flush  in  1  synchronous pipeline flush
- mem_rd_req  out  1  one-cycle read request pulse
- mem_rd_valid  in  1  read data valid
- mem_rd_data  in  DATA_WIDTH  read data
- mem_write_en  out  1  memory write strobe
- mem_data_write_out  out  DATA_WIDTH  write data
- out_valid  out  1  output slot valid
- out_ready  in  1  downstream accepts
- aluin1, aluin2  out  DATA_WIDTH each  ALU operands
- operation_out, opselect_out  out  3 each  registered control fields
- shift_number  out  SHIFT_WIDTH  shift amount
- enable_arith, enable_shift  out  1 each  unit enables, meaningful only with out_valid
- stall_cycles  out  CNT_WIDTH  saturating count of out_valid && !out_ready cycles

Behaviour:
- Opselect codes:
  - SHIFT_REG=000
  - ARITH_LOGIC=001
  - MEM_WRITE=100
  - MEM_READ=101
- Reset (reset=0, async):
  - state=RUN; all registered outputs, including stall_cycles, are 0.
  - mem_rd_req=0; in_ready=1 after release.
- FSM states: RUN, WAIT_MEM, DRAIN.
- in_ready = (state==RUN) && !flush && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Accept in RUN, loading the output slot next edge:
  - aluin1<=src1; operation_out, opselect_out <= control fields.
  - aluin2:
    - ARITH_LOGIC, flag 0 -> src2.
    - ARITH_LOGIC, flag 1 -> imm.
    - All other cases hold.
  - shift_number:
    - SHIFT_REG, imm[2]=0 -> imm[IMM_SHIFT_LSB+SHIFT_WIDTH-1:IMM_SHIFT_LSB].
    - SHIFT_REG, imm[2]=1 -> src2[SHIFT_WIDTH-1:0].
    - Otherwise 0.
  - Enables:
    - enable_arith=1 for ARITH_LOGIC.
    - enable_shift=1 for SHIFT_REG.
    - Otherwise both 0.
  - out_valid<=1, except for MEM_READ with flag=1.
- MEM_READ, flag=1 accept:
  - Capture aluin1/op/opselect.
  - mem_rd_req=1 next cycle, for one cycle.
  - out_valid<=0; go WAIT_MEM.
- WAIT_MEM:
  - On mem_rd_valid: aluin2<=mem_rd_data, enable_arith<=1, enable_shift<=0, shift_number<=0, out_valid<=1; go RUN.
  - Earliest response is the cycle after mem_rd_req.
- MEM_WRITE, flag=1 accept:
  - mem_write_en=1 combinationally in the accept cycle only.
  - mem_data_write_out=src2 always.
  - Output slot loads with both enables 0.
- Backpressure: while out_valid && !out_ready, every output register holds and stall_cycles increments, saturating at all-ones.
- out_valid falls after the out_ready handshake when no new accept occurs.
- mem_rd_valid outside WAIT/DRAIN is ignored.
- flush (sync, highest priority after reset):
  - out_valid<=0, enables<=0; no accept that cycle; mem_write_en forced 0.
  - In WAIT_MEM (or same cycle as mem_rd_req) -> DRAIN.
  - DRAIN discards the next mem_rd_valid, then -> RUN.
  - flush in DRAIN stays in DRAIN.
- Simultaneous mem_rd_valid and flush in WAIT_MEM: data discarded, -> RUN.
- Mid-operation reset aborts everything immediately; no request is replayed.

Decomposition:
- Package exec_pkg:
  - opselect localparams
  - control field bit positions
  - typedef enum logic[1:0] {RUN, WAIT_MEM, DRAIN} exec_state_t
  - packed struct for the decoded control word
- One combinational sub-module exec_ctrl_decode: control_in/imm/src2 -> decoded fields, operand-select code, shift amount, enables.
- The FSM, output register slot and counter live in the top.

Test Plan:
- Reset then ARITH_LOGIC flag 1 (control_in=7'b010_1_001), src1=5, imm=9, out_ready=1 -> next cycle out_valid=1, aluin1=5, aluin2=9, operation_out=3'b010, enable_arith=1.
- SHIFT_REG with imm[2]=0, imm[10:6]=5'd13 -> shift_number=13, enable_shift=1. Repeat with imm[2]=1, src2=32'h1F -> shift_number=31.
- MEM_READ flag 1, mem_rd_valid 3 cycles after mem_rd_req with data 32'hDEADBEEF -> in_ready=0 during wait; then out_valid=1, aluin2=DEADBEEF, enable_arith=1.
- out_ready=0 for 4 cycles with out_valid=1 -> outputs stable, in_ready=0, stall_cycles=4. CNT_WIDTH=2 with 5 stalls -> stall_cycles=3.
- flush during WAIT_MEM, response arrives 2 cycles later -> response discarded, out_valid stays 0, then RUN and in_ready=1.
- MEM_WRITE flag 1 with src2=32'hA5 -> mem_write_en=1 for one cycle, mem_data_write_out=A5. Same instruction with flush=1 -> mem_write_en=0. Assert reset mid-WAIT_MEM -> all outputs 0 immediately.
